// File: rtl/datapath_controller_pkg.sv
// Shared constants and types for the datapath control FSM.
// Holds opcode/op encodings, the state encoding and the decoded-instruction struct.
package datapath_controller_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_WRITE_IMM = 3'd2;
    localparam logic [2:0] ST_GET_A     = 3'd3;
    localparam logic [2:0] ST_GET_B     = 3'd4;
    localparam logic [2:0] ST_ALU       = 3'd5;
    localparam logic [2:0] ST_WRITE_REG = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT      = ST_WAIT,
        S_DECODE    = ST_DECODE,
        S_WRITE_IMM = ST_WRITE_IMM,
        S_GET_A     = ST_GET_A,
        S_GET_B     = ST_GET_B,
        S_ALU       = ST_ALU,
        S_WRITE_REG = ST_WRITE_REG
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
        logic       mov_imm;
        logic       mov_reg;
        logic       alu;
        logic       cmp;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Control interface between instruction fetch, the controller and the register/ALU datapath.
// The controller takes the master side: it consumes s/instr and drives every strobe.
interface datapath_controller_if #(parameter int WIDTH = 16);

    logic             s;
    logic [WIDTH-1:0] instr;
    logic             w;
    logic             err;
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             write;
    logic             vsel;
    logic             loada;
    logic             loadb;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic             loadc;
    logic             loads;
    logic [WIDTH-1:0] datapath_in;

    modport master (
        input  s, instr,
        output w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, datapath_in
    );

    modport slave (
        output s, instr,
        input  w, err, readnum, writenum, write, vsel, loada, loadb,
               asel, bsel, shift, ALUop, loadc, loads, datapath_in
    );

endinterface

// File: rtl/datapath_controller_instr_decode.sv
// Splits the latched instruction into fields, instruction class and sign-extended imm8.
// Latency: purely combinational.
// Backpressure: none; it follows instr_q directly.
module datapath_controller_instr_decode
    import datapath_controller_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] instr_q,
    output dec_t             dec,
    output logic [WIDTH-1:0] imm_ext
);

    logic [2:0] opcode;

    always_comb begin
        opcode      = instr_q[15:13];
        dec         = '0;
        dec.op      = instr_q[12:11];
        dec.rn      = instr_q[10:8];
        dec.rd      = instr_q[7:5];
        dec.sh      = instr_q[4:3];
        dec.rm      = instr_q[2:0];
        dec.mov_imm = (opcode == OPC_MOV) && (dec.op == OP_MOV_IMM);
        dec.mov_reg = (opcode == OPC_MOV) && (dec.op == OP_MOV_REG);
        dec.alu     = (opcode == OPC_ALU);
        dec.cmp     = dec.alu && (dec.op == ALU_CMP);
        dec.illegal = !(dec.mov_imm || dec.mov_reg || dec.alu);
    end

    assign imm_ext = {{(WIDTH-8){instr_q[7]}}, instr_q[7:0]};

endmodule

// File: rtl/datapath_controller.sv
// Sequences the register/ALU datapath strobes for one accepted instruction.
// Latency: 2 (illegal) to 6 (ADD/AND/MVN) cycles from s accepted back to w=1.
// Backpressure: s is only sampled while w=1; s in any other state is dropped.
module datapath_controller
    import datapath_controller_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] instr_q;
    logic             err_q;
    dec_t             dec;
    logic [WIDTH-1:0] imm_ext;

    datapath_controller_instr_decode #(.WIDTH(WIDTH)) u_decode (
        .instr_q (instr_q),
        .dec     (dec),
        .imm_ext (imm_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_WAIT;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && bus.s) begin
                instr_q <= bus.instr;
                err_q   <= 1'b0;
            end else if (state == S_DECODE && dec.illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Register selects idle on Rn so the register file address stays stable.
    always_comb begin
        state_nxt    = state;
        bus.w        = (state == S_WAIT);
        bus.readnum  = dec.rn;
        bus.writenum = dec.rn;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        case (state)
            S_WAIT: begin
                if (bus.s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (dec.mov_imm)      state_nxt = S_WRITE_IMM;
                else if (dec.mov_reg) state_nxt = S_GET_B;
                else if (dec.alu)     state_nxt = S_GET_A;
                else                  state_nxt = S_WAIT;
            end
            S_WRITE_IMM: begin
                bus.vsel  = 1'b1;
                bus.write = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                bus.loada = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = dec.rm;
                bus.loadb   = 1'b1;
                state_nxt   = S_ALU;
            end
            S_ALU: begin
                bus.shift = dec.sh;
                if (dec.mov_reg) begin
                    bus.asel  = 1'b1;
                    bus.ALUop = ALU_ADD;
                end else begin
                    bus.ALUop = dec.op;
                end
                // CMP only updates status; nothing is written back.
                if (dec.cmp) begin
                    bus.loads = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_nxt = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                bus.writenum = dec.rd;
                bus.write    = 1'b1;
                state_nxt    = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign bus.err         = err_q;
    assign bus.datapath_in = imm_ext;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: cycle-by-cycle strobe checks per instruction.
module tb_datapath_controller;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    datapath_controller_if #(.WIDTH(16)) bus ();

    datapath_controller #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {bus.w, bus.err, bus.readnum, bus.writenum, bus.write, bus.vsel,
                  bus.loada, bus.loadb, bus.asel, bus.bsel, bus.shift, bus.ALUop,
                  bus.loadc, bus.loads};

    // Expected-vector builder, same field order as obs.
    function automatic logic [19:0] ev(input logic w, input logic e,
                                       input logic [2:0] rn, input logic [2:0] wn,
                                       input logic wr, input logic vs,
                                       input logic la, input logic lb,
                                       input logic as, input logic bs,
                                       input logic [1:0] sh, input logic [1:0] op,
                                       input logic lc, input logic ls);
        return {w, e, rn, wn, wr, vs, la, lb, as, bs, sh, op, lc, ls};
    endfunction

    task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.s    = 1'b0;
        bus.instr = 16'h0000;
        #3;
        chk("reset_strobes", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        chk("reset_dpin", {4'h0, bus.datapath_in}, 20'h00000);
        step();
        reset = 1'b0;
        step();

        // MOV R0,#7
        bus.s = 1'b1; bus.instr = 16'hD007;
        step(); bus.s = 1'b0;
        chk("movi7_decode", obs, ev(0,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("movi7_write", obs, ev(0,0,3'd0,3'd0,1,1,0,0,0,0,2'd0,2'd0,0,0));
        chk("movi7_dpin", {4'h0, bus.datapath_in}, 20'h00007);
        step();
        chk("movi7_done", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // MOV R1,#-2; instr changes after capture must not matter
        bus.s = 1'b1; bus.instr = 16'hD1FE;
        step(); bus.s = 1'b0; bus.instr = 16'h0000;
        chk("movim2_decode", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("movim2_write", obs, ev(0,0,3'd1,3'd1,1,1,0,0,0,0,2'd0,2'd0,0,0));
        chk("movim2_dpin", {4'h0, bus.datapath_in}, 20'h0FFFE);
        step();
        chk("movim2_done", obs, ev(1,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // ADD R2,R1,R0 with a stray s during GET_A
        bus.s = 1'b1; bus.instr = 16'hA140;
        step(); bus.s = 1'b0;
        chk("add_decode", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("add_geta", obs, ev(0,0,3'd1,3'd1,0,0,1,0,0,0,2'd0,2'd0,0,0));
        bus.s = 1'b1; bus.instr = 16'hD007;
        step(); bus.s = 1'b0;
        chk("add_getb", obs, ev(0,0,3'd0,3'd1,0,0,0,1,0,0,2'd0,2'd0,0,0));
        step();
        chk("add_alu", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,1,0));
        step();
        chk("add_wr", obs, ev(0,0,3'd1,3'd2,1,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("add_done", obs, ev(1,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // CMP R1,R0
        bus.s = 1'b1; bus.instr = 16'hA900;
        step(); bus.s = 1'b0;
        chk("cmp_decode", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("cmp_geta", obs, ev(0,0,3'd1,3'd1,0,0,1,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("cmp_getb", obs, ev(0,0,3'd0,3'd1,0,0,0,1,0,0,2'd0,2'd0,0,0));
        step();
        chk("cmp_alu", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd1,0,1));
        step();
        chk("cmp_done", obs, ev(1,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // MOV R3,R5,LSL#1
        bus.s = 1'b1; bus.instr = 16'hC06D;
        step(); bus.s = 1'b0;
        chk("movr_decode", obs, ev(0,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("movr_getb", obs, ev(0,0,3'd5,3'd0,0,0,0,1,0,0,2'd0,2'd0,0,0));
        step();
        chk("movr_alu", obs, ev(0,0,3'd0,3'd0,0,0,0,0,1,0,2'd1,2'd0,1,0));
        step();
        chk("movr_wr", obs, ev(0,0,3'd0,3'd3,1,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("movr_done", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // Illegal, then a legal instruction clears err
        bus.s = 1'b1; bus.instr = 16'hE000;
        step(); bus.s = 1'b0;
        chk("ill_decode", obs, ev(0,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("ill_err", obs, ev(1,1,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("ill_err_sticky", obs, ev(1,1,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        bus.s = 1'b1; bus.instr = 16'hD007;
        step(); bus.s = 1'b0;
        chk("clr_decode", obs, ev(0,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("clr_write", obs, ev(0,0,3'd0,3'd0,1,1,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("clr_done", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // Reset mid-ADD while in GET_B
        bus.s = 1'b1; bus.instr = 16'hA140;
        step(); bus.s = 1'b0;
        step();
        step();
        chk("rst_pre_getb", obs, ev(0,0,3'd0,3'd1,0,0,0,1,0,0,2'd0,2'd0,0,0));
        #2 reset = 1'b1;
        #1;
        chk("rst_async", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        chk("rst_async_dpin", {4'h0, bus.datapath_in}, 20'h00000);
        step();
        chk("rst_hold1", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("rst_hold2", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));
        reset = 1'b0;
        step();
        chk("rst_idle", obs, ev(1,0,3'd0,3'd0,0,0,0,0,0,0,2'd0,2'd0,0,0));

        // Normal operation after reset: MOV R1,#-2
        bus.s = 1'b1; bus.instr = 16'hD1FE;
        step(); bus.s = 1'b0;
        chk("post_decode", obs, ev(0,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));
        step();
        chk("post_write", obs, ev(0,0,3'd1,3'd1,1,1,0,0,0,0,2'd0,2'd0,0,0));
        chk("post_dpin", {4'h0, bus.datapath_in}, 20'h0FFFE);
        step();
        chk("post_done", obs, ev(1,0,3'd1,3'd1,0,0,0,0,0,0,2'd0,2'd0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
